shift_register_8bit: RTL and testbench



---
 rtl/shift_register_8bit_pkg.sv | 6 +
 rtl/shift_register_8bit_shift_dir_mux.sv | 15 +
 rtl/shift_register_8bit.sv | 24 ++
 tb/tb_shift_register_8bit.sv | 81 ++++++++
 4 files changed

// File: rtl/shift_register_8bit_pkg.sv
// shift_register_8bit_pkg: shared direction encoding and default width
package shift_register_8bit_pkg;
  localparam logic DIR_LEFT = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/shift_register_8bit_shift_dir_mux.sv
// shift_dir_mux: next-state select for a bidirectional serial-in shift
module shift_dir_mux
  import shift_register_8bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             mov,
  input  logic             data_in,
  output logic [WIDTH-1:0] nxt
);
  always_comb begin
    nxt = (mov == DIR_RIGHT) ? {data_in, cur[WIDTH-1:1]} : {cur[WIDTH-2:0], data_in};
  end
endmodule

// File: rtl/shift_register_8bit.sv
// shift_register_8bit: serial-in/parallel-out bidirectional shift register
module shift_register_8bit
  import shift_register_8bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mov,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out
);
  logic [WIDTH-1:0] nxt;
  shift_dir_mux #(.WIDTH(WIDTH)) u_mux (
    .cur(data_out),
    .mov(mov),
    .data_in(data_in),
    .nxt(nxt)
  );
  always_ff @(posedge clk) begin
    if (reset) data_out <= '0;
    else data_out <= nxt;
  end
endmodule

// File: tb/tb_shift_register_8bit.sv
// tb_shift_register_8bit: randomized and directed checks against an arithmetic model
module tb_shift_register_8bit;
  localparam int W = 8;
  logic clk = 1'b0;
  logic reset, mov, data_in;
  logic [W-1:0] data_out;
  int model = 0;
  int vectors = 0;
  int miscompares = 0;
  int rs[8] = '{1, 1, 0, 1, 1, 0, 1, 1};

  shift_register_8bit #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .mov(mov),
    .data_in(data_in),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: left shift is doubling plus the new bit, right shift is halving plus MSB weight.
  task automatic step(input logic r, input logic m, input logic d);
    @(negedge clk);
    reset = r;
    mov = m;
    data_in = d;
    @(posedge clk);
    #1;
    if (r === 1'b1) model = 0;
    else if (m === 1'b1) model = model / 2 + ((d === 1'b1) ? 2 ** (W - 1) : 0);
    else model = (model * 2 + ((d === 1'b1) ? 1 : 0)) % (2 ** W);
    check("model", data_out, model[W-1:0]);
  endtask

  initial begin
    reset = 1'b1;
    mov = 1'b0;
    data_in = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    check("reset", data_out, 8'h00);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, (i % 2) == 0);
    check("left_aa", data_out, 8'hAA);
    step(1'b0, 1'b1, 1'b0);
    check("dir_switch", data_out, 8'h55);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, rs[i] != 0);
    check("right_db", data_out, 8'hDB);
    step(1'b0, 1'b1, 1'b1);
    check("right_ed", data_out, 8'hED);
    step(1'b1, 1'b1, 1'b1);
    check("mid_reset", data_out, 8'h00);
    step(1'b0, 1'b0, 1'b1);
    check("resume", data_out, 8'h01);
    step(1'b1, 1'bx, 1'bx);
    check("rst_prio_x0", data_out, 8'h00);
    step(1'b1, 1'bx, 1'bx);
    check("rst_prio_x1", data_out, 8'h00);
    step(1'b1, 1'b1, 1'b1);
    check("rst_prio_1", data_out, 8'h00);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1);
    check("fill_ff", data_out, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] e;
      e = 8'hFF >> (i + 1);
      step(1'b0, 1'b1, 1'b0);
      check("flush", data_out, e);
    end
    for (int i = 0; i < 300; i++)
      step(($urandom % 16) == 0, $urandom % 2 == 1, $urandom % 2 == 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
